// File: rtl/mem_copier.sv
`default_nettype none
// ============================================================================
// Module      : mem_copier
// Description : Word-by-word block copier. Each word is read from
//               src+i, held for RD_LAT cycles until the memory returns it,
//               then written to dst+i, accumulating a 32-bit checksum of
//               the copied words.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_copier #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  src_addr,
    input  logic [7:0]  dst_addr,
    input  logic [8:0]  len,
    output logic        busy,
    output logic        done,
    output logic [31:0] checksum,
    output logic [7:0]  mem_address,
    output logic        mem_mode,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_RD   = 3'd1;
    localparam logic [2:0] c_WAIT = 3'd2;
    localparam logic [2:0] c_WR   = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;

    // Count value reached on the final WAIT cycle
    localparam logic [2:0] c_WAIT_LAST = 3'(RD_LAT - 1);

    logic [2:0]  r_state;
    logic [7:0]  r_src;
    logic [7:0]  r_dst;
    logic [8:0]  r_len;
    logic [8:0]  r_idx;
    logic [2:0]  r_wcnt;
    logic [31:0] r_hold;
    logic [31:0] r_sum;
    logic        w_wr_active;

    // Copy sequencer: parameter capture, read wait, data capture and index advance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_src   <= 8'd0;
            r_dst   <= 8'd0;
            r_len   <= 9'd0;
            r_idx   <= 9'd0;
            r_wcnt  <= 3'd0;
            r_hold  <= 32'd0;
            r_sum   <= 32'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_src   <= src_addr;
                        r_dst   <= dst_addr;
                        r_len   <= len;
                        r_idx   <= 9'd0;
                        r_sum   <= 32'd0;
                        r_state <= (len == 9'd0) ? c_DONE : c_RD;
                    end
                end
                c_RD: begin
                    r_wcnt  <= 3'd0;
                    r_state <= c_WAIT;
                end
                c_WAIT: begin
                    if (r_wcnt == c_WAIT_LAST) begin
                        r_hold  <= mem_data_out;
                        r_sum   <= r_sum + mem_data_out;
                        r_state <= c_WR;
                    end else begin
                        r_wcnt <= r_wcnt + 3'd1;
                    end
                end
                c_WR: begin
                    r_idx   <= r_idx + 9'd1;
                    r_state <= ((r_idx + 9'd1) == r_len) ? c_DONE : c_RD;
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // A write is suppressed while rst is high so the reset edge never stores data
    assign w_wr_active = (r_state == c_WR) && !rst;

    // Memory address: source during the read phase, destination during the write
    always_comb begin
        mem_address = 8'd0;
        case (r_state)
            c_RD, c_WAIT: mem_address = r_src + r_idx[7:0];
            c_WR:         mem_address = r_dst + r_idx[7:0];
            default:      mem_address = 8'd0;
        endcase
    end

    assign mem_mode    = ~w_wr_active;
    assign mem_data_in = r_hold;
    assign checksum    = r_sum;
    assign busy        = (r_state == c_RD) || (r_state == c_WAIT) || (r_state == c_WR);
    assign done        = (r_state == c_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mem_copier.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_copier
// Description : Scoreboard bench for mem_copier. Two instances (RD_LAT=1 and
//               RD_LAT=3) each drive their own behavioural memory. Expected
//               writes and done/checksum events are queued from a reference
//               model and popped by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_copier;

    typedef struct packed {
        logic        kind;   // 0 = write, 1 = done
        logic        inst;
        logic [7:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_v        [2];
    logic        start_v      [2];
    logic [7:0]  src_v        [2];
    logic [7:0]  dst_v        [2];
    logic [8:0]  len_v        [2];
    logic        busy_v       [2];
    logic        done_v       [2];
    logic [31:0] checksum_v   [2];
    logic [7:0]  mem_address_v[2];
    logic        mem_mode_v   [2];
    logic [31:0] mem_data_in_v[2];
    logic [31:0] mem_data_out_v[2];

    logic [31:0] mem     [2][256];
    logic [31:0] ref_mem [2][256];
    logic [31:0] pipe0;
    logic [31:0] pipe1 [3];

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mem_copier #(.RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]),
        .src_addr(src_v[0]), .dst_addr(dst_v[0]), .len(len_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .checksum(checksum_v[0]),
        .mem_address(mem_address_v[0]), .mem_mode(mem_mode_v[0]),
        .mem_data_in(mem_data_in_v[0]), .mem_data_out(mem_data_out_v[0])
    );

    mem_copier #(.RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]),
        .src_addr(src_v[1]), .dst_addr(dst_v[1]), .len(len_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .checksum(checksum_v[1]),
        .mem_address(mem_address_v[1]), .mem_mode(mem_mode_v[1]),
        .mem_data_in(mem_data_in_v[1]), .mem_data_out(mem_data_out_v[1])
    );

    // Behavioural memories with RD_LAT-deep read pipelines
    always @(posedge clk) begin
        if (!mem_mode_v[0]) mem[0][mem_address_v[0]] = mem_data_in_v[0];
        if (!mem_mode_v[1]) mem[1][mem_address_v[1]] = mem_data_in_v[1];
        pipe0    <= mem[0][mem_address_v[0]];
        pipe1[0] <= mem[1][mem_address_v[1]];
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end
    assign mem_data_out_v[0] = pipe0;
    assign mem_data_out_v[1] = pipe1[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic observe(input int k, input logic kind, input logic [7:0] a, input logic [31:0] d);
        exp_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: inst %0d kind %0d addr %0h data %0h, expected none", k, kind, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.inst !== 1'(k) || e.addr !== a || e.data !== d) begin
                n_fail++;
                $display("FAIL scoreboard: got inst %0d kind %0d addr %0h data %0h, expected inst %0d kind %0d addr %0h data %0h",
                         k, kind, a, d, e.inst, e.kind, e.addr, e.data);
            end
        end
    endtask

    // Monitor: every write strobe and done pulse is matched against the queue
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_mode_v[k] == 1'b0) observe(k, 1'b0, mem_address_v[k], mem_data_in_v[k]);
            if (done_v[k] == 1'b1)     observe(k, 1'b1, 8'd0, checksum_v[k]);
        end
    end

    task automatic preload(input int inst);
        logic [31:0] v;
        for (int a = 0; a < 256; a++) begin
            v = $urandom;
            mem[inst][a]     = v;
            ref_mem[inst][a] = v;
        end
    endtask

    task automatic poke_mem(input int inst, input int a, input logic [31:0] v);
        mem[inst][a]     = v;
        ref_mem[inst][a] = v;
    endtask

    // One full copy: model, drive, observe cycle-level behaviour
    task automatic run_copy(input int inst, input logic [7:0] s, input logic [7:0] d,
                            input logic [8:0] n, input bit poke);
        int          lat, exp_busy, busy_c, done_c, low_c, done_at, cyc, mism;
        logic [31:0] sum, w;
        logic [7:0]  sa, da;
        exp_t        e;
        lat = (inst == 0) ? 1 : 3;
        exp_busy = int'(n) * (2 + lat);
        sum = 32'd0;
        for (int k = 0; k < int'(n); k++) begin
            sa = 8'(int'(s) + k);
            da = 8'(int'(d) + k);
            w  = ref_mem[inst][sa];
            ref_mem[inst][da] = w;
            sum = sum + w;
            e.kind = 1'b0; e.inst = 1'(inst); e.addr = da; e.data = w;
            exp_q.push_back(e);
        end
        e.kind = 1'b1; e.inst = 1'(inst); e.addr = 8'd0; e.data = sum;
        exp_q.push_back(e);

        @(posedge clk); #1;
        start_v[inst] = 1'b1; src_v[inst] = s; dst_v[inst] = d; len_v[inst] = n;
        @(posedge clk); #1;
        start_v[inst] = 1'b0;
        src_v[inst] = 8'($urandom); dst_v[inst] = 8'($urandom); len_v[inst] = 9'($urandom_range(1, 300));

        busy_c = 0; done_c = 0; low_c = 0; done_at = -1; cyc = 0;
        while (done_at < 0 && cyc < exp_busy + 20) begin
            @(negedge clk);
            if (poke && cyc == 1) begin
                start_v[inst] = 1'b1; src_v[inst] = 8'($urandom); dst_v[inst] = 8'($urandom);
                len_v[inst] = 9'($urandom_range(0, 256));
            end
            if (poke && cyc == 2) start_v[inst] = 1'b0;
            if (busy_v[inst]) busy_c++;
            if (!mem_mode_v[inst]) low_c++;
            if (done_v[inst]) begin done_c++; done_at = cyc; end
            cyc++;
        end
        check("done_seen", 64'(done_at >= 0), 64'd1);
        check("busy_cycles", 64'(busy_c), 64'(exp_busy));
        check("done_latency", 64'(done_at), 64'(exp_busy));
        check("write_count", 64'(low_c), 64'(n));
        @(negedge clk);
        if (done_v[inst]) done_c++;
        check("done_pulses", 64'(done_c), 64'd1);
        repeat (2) @(negedge clk);
        check("checksum_hold", 64'(checksum_v[inst]), 64'(sum));
        mism = 0;
        for (int a = 0; a < 256; a++) if (mem[inst][a] !== ref_mem[inst][a]) mism++;
        check("mem_image", 64'(mism), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  s, d;
        logic [31:0] oldw;
        exp_t        e;
        for (int k = 0; k < 2; k++) begin
            rst_v[k] = 1'b1; start_v[k] = 1'b0; src_v[k] = 8'd0; dst_v[k] = 8'd0; len_v[k] = 9'd0;
            preload(k);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_v[0] = 1'b0; rst_v[1] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_busy", 64'(busy_v[k]), 64'd0);
            check("rst_done", 64'(done_v[k]), 64'd0);
            check("rst_mode", 64'(mem_mode_v[k]), 64'd1);
            check("rst_addr", 64'(mem_address_v[k]), 64'd0);
            check("rst_wdata", 64'(mem_data_in_v[k]), 64'd0);
            check("rst_checksum", 64'(checksum_v[k]), 64'd0);
        end

        // Basic two-word copy
        poke_mem(0, 2, 32'd30);
        poke_mem(0, 3, 32'd40);
        run_copy(0, 8'd2, 8'd10, 9'd2, 1'b0);
        check("basic_w10", 64'(mem[0][10]), 64'd30);
        check("basic_w11", 64'(mem[0][11]), 64'd40);
        check("basic_sum", 64'(checksum_v[0]), 64'd70);

        // Zero-length request
        run_copy(0, 8'd5, 8'd6, 9'd0, 1'b0);
        check("len0_sum", 64'(checksum_v[0]), 64'd0);

        // Overlap with wrap-around
        poke_mem(0, 254, 32'd1);
        poke_mem(0, 255, 32'd2);
        poke_mem(0, 0, 32'd3);
        poke_mem(0, 1, 32'd4);
        run_copy(0, 8'd254, 8'd0, 9'd4, 1'b0);
        check("ovl_m0", 64'(mem[0][0]), 64'd1);
        check("ovl_m1", 64'(mem[0][1]), 64'd2);
        check("ovl_m2", 64'(mem[0][2]), 64'd1);
        check("ovl_m3", 64'(mem[0][3]), 64'd2);
        check("ovl_sum", 64'(checksum_v[0]), 64'd6);

        // Start re-asserted while busy
        run_copy(0, 8'd100, 8'd150, 9'd3, 1'b1);

        // Long read latency, single word
        run_copy(1, 8'd20, 8'd200, 9'd1, 1'b0);
        check("lat3_word", 64'(mem_data_in_v[1]), 64'(mem[1][20]));
        check("lat3_sum", 64'(checksum_v[1]), 64'(mem[1][20]));

        // Reset during WR of word 1 of a three-word copy
        s = 8'd40; d = 8'd80;
        e.kind = 1'b0; e.inst = 1'b0; e.addr = d; e.data = ref_mem[0][s];
        exp_q.push_back(e);
        ref_mem[0][d] = ref_mem[0][s];
        oldw = ref_mem[0][8'(d + 8'd2)];
        @(posedge clk); #1;
        start_v[0] = 1'b1; src_v[0] = s; dst_v[0] = d; len_v[0] = 9'd3;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_in_wr", 64'(mem_mode_v[0]), 64'd0);
        check("midrst_wr_addr", 64'(mem_address_v[0]), 64'(8'(d + 8'd1)));
        rst_v[0] = 1'b1;
        @(posedge clk); #1;
        rst_v[0] = 1'b0;
        check("midrst_busy", 64'(busy_v[0]), 64'd0);
        check("midrst_mode", 64'(mem_mode_v[0]), 64'd1);
        check("midrst_sum", 64'(checksum_v[0]), 64'd0);
        check("midrst_wdata", 64'(mem_data_in_v[0]), 64'd0);
        repeat (10) @(posedge clk);
        check("midrst_word2", 64'(mem[0][8'(d + 8'd2)]), 64'(oldw));
        check("midrst_word1", 64'(mem[0][8'(d + 8'd1)]), 64'(ref_mem[0][8'(d + 8'd1)]));

        // Reset wins over a simultaneous start
        #1;
        rst_v[1] = 1'b1; start_v[1] = 1'b1; src_v[1] = 8'd1; dst_v[1] = 8'd2; len_v[1] = 9'd5;
        @(posedge clk); #1;
        rst_v[1] = 1'b0; start_v[1] = 1'b0;
        check("rstprio_busy", 64'(busy_v[1]), 64'd0);
        @(posedge clk); #1;
        check("rstprio_busy2", 64'(busy_v[1]), 64'd0);
        check("rstprio_done", 64'(done_v[1]), 64'd0);

        // Randomized copies on both latencies, including a full wrap
        for (int t = 0; t < 6; t++) begin
            run_copy(0, 8'($urandom), 8'($urandom), 9'($urandom_range(0, 24)), 1'($urandom_range(0, 1)));
            run_copy(1, 8'($urandom), 8'($urandom), 9'($urandom_range(0, 24)), 1'($urandom_range(0, 1)));
        end
        run_copy(0, 8'($urandom), 8'($urandom), 9'd256, 1'b0);
        run_copy(1, 8'($urandom), 8'($urandom), 9'd256, 1'b1);

        repeat (5) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_copier.md
MEM_COPIER -- requirements
Module: mem_copier

Interface
REQ-001 SHALL have parameter RD_LAT, default 1: cycles from a read-address cycle to valid mem_data_out (1..4).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a block copy; sampled only in IDLE.
REQ-005 SHALL have port src_addr  input  8  first source word address.
REQ-006 SHALL have port dst_addr  input  8  first destination word address.
REQ-007 SHALL have port len  input  9  word count, 0..256.
REQ-008 SHALL have port busy  output  1  copy in progress.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port checksum  output  32  sum of copied words, mod 2^32.
REQ-011 SHALL have port mem_address  output  8  to the memory's address input.
REQ-012 SHALL have port mem_mode  output  1  to the memory's mode input: 1 = read, 0 = write.
REQ-013 SHALL have port mem_data_in  output  32  write data to the memory.
REQ-014 SHALL have port mem_data_out  input  32  read data from the memory.

Function
REQ-015 SHALL implement the FSM states IDLE, RD, WAIT, WR and DONE.
REQ-016 SHALL make transitions as follows:
- IDLE->RD on start with len!=0.
- IDLE->DONE on start with len==0.
- RD->WAIT.
- WAIT->WR after RD_LAT cycles in WAIT.
- WR->RD if words remain, else WR->DONE.
- DONE->IDLE unconditionally.
REQ-017 SHALL latch src_addr, dst_addr and len on the accepting edge, and SHALL clear checksum and the word index i on that same edge.
REQ-018 SHALL ignore start in every state except IDLE; inputs changing after acceptance SHALL have no effect.
REQ-019 SHALL, in RD, drive mem_address = src+i (mod 256) and mem_mode = 1.
REQ-020 SHALL, in WAIT, hold mem_mode = 1 and keep mem_address unchanged.
REQ-021 SHALL capture mem_data_out into a holding register on the edge that ends the last WAIT cycle, and SHALL add it to checksum on that same edge.
REQ-022 SHALL, in WR, drive mem_address = dst+i (mod 256), mem_mode = 0 and mem_data_in = the holding register; i SHALL increment on the edge that ends WR.
REQ-023 SHALL make mem_mode = 0 only in WR; every other state SHALL drive mem_mode = 1, with mem_data_in held at its last value.
REQ-024 SHALL cost 2+RD_LAT cycles per word, so a copy of N words takes N*(2+RD_LAT) busy cycles followed by 1 DONE cycle.
REQ-025 SHALL assert busy in RD, WAIT and WR, and deassert it in IDLE and DONE.
REQ-026 SHALL assert done only in the DONE state, high for exactly one cycle.
REQ-027 SHALL copy in ascending order; word i SHALL be read after word i-1 is written.
- Overlapping ranges with dst>src therefore propagate earlier words; this is the required behaviour.
REQ-028 SHALL wrap source and destination addresses modulo 256 independently.
- len=256 copies all locations.
REQ-029 SHALL hold checksum stable from DONE until the next accepted start.

Reset
REQ-030 SHALL, while rst is high at a clock edge, force the following regardless of state, including mid-copy:
- state = IDLE;
- busy = 0, done = 0;
- mem_mode = 1, mem_address = 0, mem_data_in = 0;
- checksum = 0, holding register = 0, i = 0.
REQ-031 SHALL NOT issue any write on the reset edge or on the cycle following it.
REQ-032 SHALL give rst priority over start in the same cycle.

Verification
REQ-033 SHALL cover: mem preloaded with [2]=30, [3]=40; start with src=2, dst=10, len=2, RD_LAT=1 -> busy for 6 cycles; writes [10]=30, [11]=40; done pulses once; checksum=70.
REQ-034 SHALL cover: start with len=0 -> done exactly one cycle after acceptance; busy never high; mem_mode stays 1.
REQ-035 SHALL cover: src=254, dst=0, len=4 with [254,255,0,1]=1,2,3,4 -> mem[0..3]=1,2,1,2 (overlap propagation); checksum=6.
REQ-036 SHALL cover: rst asserted during WR of word 1 of a 3-word copy -> next cycle IDLE, busy=0, mem_mode=1, checksum=0; word 2 never written.
REQ-037 SHALL cover: start re-asserted while busy -> ignored; the copy completes with the original parameters; exactly one done pulse.
REQ-038 SHALL cover: RD_LAT=3, len=1 -> busy for 5 cycles; the captured word equals the source word.
